keypad_matrix_scanner: RTL and testbench

KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

---
 rtl/keypad_matrix_scanner_pkg.sv | 9 +
 rtl/keypad_matrix_scanner_sync_2ff.sv | 20 ++
 rtl/keypad_matrix_scanner.sv | 124 ++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_matrix_scanner_pkg.sv
// keypad_matrix_scanner_pkg: shared state encoding, column drive patterns and key code width
package keypad_matrix_scanner_pkg;
    localparam int KEY_W = 4;
    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;
    localparam logic [3:0] COL_ONEHOT [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/keypad_matrix_scanner_sync_2ff.sv
// sync_2ff: 4-bit two-flop synchronizer, idles high to match the pulled-up rows
module sync_2ff (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);
    logic [3:0] r_meta;
    logic [3:0] r_sync;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 4'hF;
            r_sync <= 4'hF;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
    assign o_q = r_sync;
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x4 keypad scanner with debounce, one-entry key event holding register
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic             overflow
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_dwell;
    logic [1:0]       r_col_idx, w_col_idx_nxt;
    logic [DEB_W-1:0] r_deb, w_deb_nxt;
    logic [1:0]       r_cand, w_cand_nxt;
    logic [KEY_W-1:0] r_key_code;
    logic             r_key_valid, r_overflow;
    logic [3:0]       w_row;
    logic             w_sample, w_cand_low, w_deb_last, w_emit;

    sync_2ff u_sync (.i_clk(clk), .i_rst_n(reset), .i_d(row), .o_q(w_row));

    assign w_sample   = r_dwell == DIV_W'(SCAN_DIV - 1);
    assign w_cand_low = !w_row[r_cand];
    assign w_deb_last = r_deb == DEB_W'(DEBOUNCE_CNT - 1);

    // every decision is taken only on the last cycle of a column dwell
    always_comb begin
        w_state_nxt   = r_state;
        w_col_idx_nxt = r_col_idx;
        w_deb_nxt     = r_deb;
        w_cand_nxt    = r_cand;
        w_emit        = 1'b0;
        if (w_sample) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_row != 4'hF) begin
                        w_cand_nxt  = lowest_low(w_row);
                        w_deb_nxt   = '0;
                        w_state_nxt = ST_DEBOUNCE;
                    end else
                        w_col_idx_nxt = r_col_idx + 2'd1;
                end
                ST_DEBOUNCE: begin
                    if (!w_cand_low) begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                        w_state_nxt   = ST_SCAN;
                    end else if (w_deb_last) begin
                        w_emit      = 1'b1;
                        w_deb_nxt   = '0;
                        w_state_nxt = ST_PRESSED;
                    end else
                        w_deb_nxt = r_deb + 1'b1;
                end
                ST_PRESSED: begin
                    if (!w_cand_low) begin
                        w_deb_nxt   = '0;
                        w_state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_cand_low) begin
                        w_deb_nxt   = '0;
                        w_state_nxt = ST_PRESSED;
                    end else if (w_deb_last) begin
                        w_deb_nxt     = '0;
                        w_col_idx_nxt = r_col_idx + 2'd1;
                        w_state_nxt   = ST_SCAN;
                    end else
                        w_deb_nxt = r_deb + 1'b1;
                end
                default: w_state_nxt = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_SCAN;
            r_dwell   <= '0;
            r_col_idx <= '0;
            r_deb     <= '0;
            r_cand    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dwell   <= w_sample ? '0 : r_dwell + 1'b1;
            r_col_idx <= w_col_idx_nxt;
            r_deb     <= w_deb_nxt;
            r_cand    <= w_cand_nxt;
        end
    end

    // a blocked emit keeps the pending code and records the loss
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_emit) begin
            if (!r_key_valid || key_ready) begin
                r_key_code  <= {r_cand, r_col_idx};
                r_key_valid <= 1'b1;
            end else
                r_overflow <= 1'b1;
        end else if (key_ready)
            r_key_valid <= 1'b0;
    end

    assign col       = COL_ONEHOT[r_col_idx];
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign overflow  = r_overflow;
    assign key_held  = (r_state == ST_PRESSED) || (r_state == ST_RELEASE);
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: keypad-model bench with scan table, directed corner cases and randomized presses
module tb_keypad_matrix_scanner;
    localparam int SD = 4;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_ready = 1'b0;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_held, overflow;
    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;
    int stab_err = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [3:0] prev_c = '0;
    bit collect = 1'b0;
    bit rand_ready = 1'b0;
    int got[$];
    int expq[$];

    typedef struct { int cyc; logic [3:0] col; } scan_vec_t;
    scan_vec_t tbl[10];

    always #5 clk = ~clk;

    // physical keypad: a row reads low when a pressed key sits on a driven column
    always_comb
        for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r*4 +: 4] & ~col);

    keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overflow(overflow)
    );

    always @(negedge clk) begin
        if (prev_v && !prev_r && key_valid && key_code != prev_c) stab_err++;
        if (collect && key_valid && key_ready) got.push_back(int'(key_code));
        prev_v = key_valid;
        prev_r = key_ready;
        prev_c = key_code;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) key_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_col(input logic [3:0] c);
        int k = 0;
        while (col == c && k < 40) begin step(1); k++; end
        while (col != c && k < 80) begin step(1); k++; end
        chk("wait_col", int'(col), int'(c));
    endtask

    task automatic wait_valid(input logic v, input string nm);
        int k = 0;
        while (key_valid != v && k < 100) begin step(1); k++; end
        chk(nm, int'(key_valid), int'(v));
    endtask

    task automatic wait_held(input logic v, input string nm);
        int k = 0;
        while (key_held != v && k < 100) begin step(1); k++; end
        chk(nm, int'(key_held), int'(v));
    endtask

    task automatic pulse_ready();
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(3);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, rise, a, b, hold;
        tbl = '{'{0, 4'b1110}, '{3, 4'b1110}, '{4, 4'b1101}, '{7, 4'b1101}, '{8, 4'b1011},
                '{11, 4'b1011}, '{12, 4'b0111}, '{15, 4'b0111}, '{16, 4'b1110}, '{19, 4'b1110}};
        #12;
        chk("rst_col", int'(col), 4'b1110);
        chk("rst_code", int'(key_code), 0);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;

        k = 0;
        for (int i = 0; i < 10; i++) begin
            while (k < tbl[i].cyc) begin step(1); k++; end
            chk($sformatf("scan_col_c%0d", k), int'(col), int'(tbl[i].col));
            chk("scan_valid", int'(key_valid), 0);
        end

        // steady key at row 2, column 1
        wait_col(4'b1101);
        pressed[9] = 1'b1;
        rise = 0;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            if (key_valid && rise == 0) rise = i;
        end
        chk("latency_window", int'(rise >= DC * SD && rise <= (DC + 1) * SD + 1), 1);
        chk("press_code", int'(key_code), 9);
        chk("press_valid", int'(key_valid), 1);
        chk("press_held", int'(key_held), 1);
        pulse_ready();
        chk("consume_valid", int'(key_valid), 0);
        chk("consume_held", int'(key_held), 1);
        pressed[9] = 1'b0;
        wait_held(1'b0, "release_held");
        chk("release_next_col", int'(col), 4'b1011);
        chk("release_valid", int'(key_valid), 0);

        // bounce: low for two samples then high
        wait_col(4'b1101);
        pressed[9] = 1'b1;
        step(2 * SD);
        pressed[9] = 1'b0;
        step(SD);
        chk("bounce_col", int'(col), 4'b1011);
        chk("bounce_valid", int'(key_valid), 0);
        chk("bounce_held", int'(key_held), 0);
        step(SD);
        chk("bounce_resume_col", int'(col), 4'b0111);

        // emit coincident with handshake
        pressed[6] = 1'b1;
        wait_valid(1'b1, "c_valid");
        chk("c_code", int'(key_code), 6);
        pressed[6] = 1'b0;
        wait_held(1'b0, "c_release");
        wait_col(4'b1110);
        pressed[12] = 1'b1;
        step(DC * SD + SD - 1);
        chk("c_kept", int'(key_code), 6);
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
        chk("coinc_valid", int'(key_valid), 1);
        chk("coinc_code", int'(key_code), 12);
        chk("coinc_ovf", int'(overflow), 0);
        pulse_ready();
        chk("coinc_consumed", int'(key_valid), 0);
        pressed[12] = 1'b0;
        wait_held(1'b0, "d_release");

        // two events with no consumer
        pressed[3] = 1'b1; step(60); pressed[3] = 1'b0; step(40);
        pressed[14] = 1'b1; step(60); pressed[14] = 1'b0; step(40);
        chk("ovf_code", int'(key_code), 3);
        chk("ovf_valid", int'(key_valid), 1);
        chk("ovf_flag", int'(overflow), 1);
        pulse_ready();
        chk("ovf_consumed", int'(key_valid), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // reset while PRESSED
        pressed[5] = 1'b1;
        wait_held(1'b1, "rp_held");
        reset = 1'b0;
        #1;
        chk("rp_col", int'(col), 4'b1110);
        chk("rp_valid", int'(key_valid), 0);
        chk("rp_held0", int'(key_held), 0);
        chk("rp_ovf", int'(overflow), 0);
        chk("rp_code", int'(key_code), 0);
        step(3);
        @(negedge clk);
        reset = 1'b1;
        wait_valid(1'b1, "rp_redetect");
        chk("rp_redetect_code", int'(key_code), 5);
        pulse_ready();
        step(100);
        chk("rp_single_event", int'(key_valid), 0);
        pressed[5] = 1'b0;
        wait_held(1'b0, "rp_release");

        // randomized presses against an event-level model
        do_reset();
        got.delete();
        collect = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(0, 15);
            expq.push_back(a);
            pressed[a] = 1'b1;
            hold = $urandom_range(90, 130);
            if ($urandom_range(0, 1) == 1) begin
                b = (a + $urandom_range(1, 15)) % 16;
                step(50);
                pressed[b] = 1'b1;
                step(20);
                pressed[b] = 1'b0;
                step(hold - 70);
            end else
                step(hold);
            pressed[a] = 1'b0;
            step($urandom_range(60, 90));
        end
        rand_ready = 1'b0;
        key_ready = 1'b0;
        step(2);
        collect = 1'b0;
        chk("rand_count", got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("rand_code_%0d", i), got[i], expq[i]);
        chk("rand_ovf", int'(overflow), 0);
        chk("rand_held", int'(key_held), 0);
        chk("code_stable", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
